// File: rtl/axis_st_rst_ctrl_pkg.sv
// axis_st_rst_ctrl_pkg
//
// Shared definitions for the AXI4-Stream self-test reset controller:
//   - axis_st_rst_ctrl_state_t : sequencing state machine encoding
//   - cnt_width()              : width of the shared assert/recover down-counter
//   - idx_width()              : width of a requester index (minimum 1 bit)
package axis_st_rst_ctrl_pkg;

  // Sequencing states. ST_ASSERT doubles as the power-on state, so the
  // controller comes out of system reset already driving the downstream
  // reset low.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ASSERT  = 2'd1,
    ST_RECOVER = 2'd2,
    ST_ACK     = 2'd3
  } axis_st_rst_ctrl_state_t;

  // Smallest width that holds every value from 0 to max(A, R) - 1, i.e.
  // ceil(log2(max(A, R))), never less than one bit. Written as a bounded
  // loop so it stays a simple constant function for elaboration.
  function automatic int cnt_width(input int assert_cycles,
                                   input int recovery_cycles);
    int max_cycles;
    int w;
    max_cycles = (assert_cycles > recovery_cycles) ? assert_cycles
                                                   : recovery_cycles;
    w = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < max_cycles) begin
        w = i + 1;
      end
    end
    return (w < 1) ? 1 : w;
  endfunction

  // Width needed to name one of n requesters; a single requester still
  // gets a one-bit index so the port never collapses to zero width.
  function automatic int idx_width(input int n);
    int w;
    w = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) begin
        w = i + 1;
      end
    end
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/axis_st_rst_ctrl_penc.sv
// axis_st_rst_ctrl_penc
//
// Combinational lowest-index priority encoder. Reports the position of the
// least significant set bit of vec, and whether any bit is set at all.
//
// Ports:
//   vec   in  [NUM_REQ-1:0]            request/served mask to encode
//   idx   out [idx_width(NUM_REQ)-1:0] index of the lowest set bit (0 if none)
//   valid out 1                        high when vec has any bit set
module axis_st_rst_ctrl_penc
  import axis_st_rst_ctrl_pkg::*;
#(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]            vec,
  output logic [idx_width(NUM_REQ)-1:0] idx,
  output logic                          valid
);

  localparam int IDX_W = idx_width(NUM_REQ);

  // Scan from the top bit down so the last (lowest) set bit found wins.
  always_comb begin
    idx   = '0;
    valid = 1'b0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (vec[i]) begin
        idx   = IDX_W'(i);
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/axis_st_rst_ctrl.sv
// axis_st_rst_ctrl
//
// Reset controller for the AXI4-Stream self-test environment. Several
// requesters share one downstream reset domain. Requests are collected
// into a served mask, a timed assert/recover sequence is run on the
// downstream reset, and every requester in the mask gets a one-cycle ack.
// After system reset the same sequence runs once with an empty mask
// (power-on), which acknowledges nobody.
//
// Parameters:
//   NUM_REQ         number of requesters (1..16)
//   ASSERT_CYCLES   cycles rst_out_n is held low per sequence (>= 1)
//   RECOVERY_CYCLES cycles between reset release and ready (>= 1)
//   SEQ_CNT_W       width of the saturating completed-sequence counter
//
// Ports:
//   clk        in  1            single clock
//   reset_n    in  1            asynchronous active-low system reset
//   req        in  [NUM_REQ-1:0] level reset requests, one per requester
//   ack        out [NUM_REQ-1:0] one-cycle completion pulse per served requester
//   rst_out_n  out 1            downstream reset, active-low, registered
//   rst_out    out 1            complement of rst_out_n, registered
//   ready      out 1            downstream out of reset and recovered
//   busy       out 1            controller is not idle
//   last_src   out [idx_width(NUM_REQ)-1:0] lowest index of last served set
//   seq_count  out [SEQ_CNT_W-1:0] completed requested sequences, saturating
module axis_st_rst_ctrl
  import axis_st_rst_ctrl_pkg::*;
#(
  parameter int NUM_REQ         = 4,
  parameter int ASSERT_CYCLES   = 16,
  parameter int RECOVERY_CYCLES = 8,
  parameter int SEQ_CNT_W       = 16
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic [NUM_REQ-1:0]            req,
  output logic [NUM_REQ-1:0]            ack,
  output logic                          rst_out_n,
  output logic                          rst_out,
  output logic                          ready,
  output logic                          busy,
  output logic [idx_width(NUM_REQ)-1:0] last_src,
  output logic [SEQ_CNT_W-1:0]          seq_count
);

  localparam int CNT_W = cnt_width(ASSERT_CYCLES, RECOVERY_CYCLES);
  localparam int SRC_W = idx_width(NUM_REQ);

  // Counter reload values: each phase counts down from N-1 to 0, so the
  // phase lasts exactly N cycles including the cycle that sees zero.
  localparam logic [CNT_W-1:0]     ASSERT_LOAD  = CNT_W'(ASSERT_CYCLES - 1);
  localparam logic [CNT_W-1:0]     RECOVER_LOAD = CNT_W'(RECOVERY_CYCLES - 1);
  localparam logic [SEQ_CNT_W-1:0] SEQ_MAX      = '1;

  axis_st_rst_ctrl_state_t state;
  axis_st_rst_ctrl_state_t state_next;
  logic [CNT_W-1:0]        cnt;
  logic [CNT_W-1:0]        cnt_next;
  logic [NUM_REQ-1:0]      mask;
  logic [NUM_REQ-1:0]      mask_next;
  logic [SRC_W-1:0]        mask_low_idx;
  logic                    mask_any;

  // Lowest served requester, used for last_src; mask_any also tells us
  // whether this ACK belongs to a real request or to power-on.
  axis_st_rst_ctrl_penc #(
    .NUM_REQ(NUM_REQ)
  ) u_penc (
    .vec  (mask),
    .idx  (mask_low_idx),
    .valid(mask_any)
  );

  // Next-state logic. Requests are merged into the served mask only while
  // the downstream reset is actually asserted; anything arriving during
  // RECOVER or ACK stays pending on req and starts the next sequence from
  // IDLE, because that requester would otherwise be acked without its
  // reset having been applied after it asked.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    mask_next  = mask;
    unique case (state)
      ST_IDLE: begin
        if (|req) begin
          mask_next  = req;
          cnt_next   = ASSERT_LOAD;
          state_next = ST_ASSERT;
        end
      end
      ST_ASSERT: begin
        mask_next = mask | req;
        if (cnt == '0) begin
          cnt_next   = RECOVER_LOAD;
          state_next = ST_RECOVER;
        end else begin
          cnt_next = cnt - CNT_W'(1);
        end
      end
      ST_RECOVER: begin
        if (cnt == '0) begin
          state_next = ST_ACK;
        end else begin
          cnt_next = cnt - CNT_W'(1);
        end
      end
      ST_ACK: begin
        mask_next  = '0;
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // State register plus registered outputs. The downstream reset and ready
  // are decoded from the next state so they change on the same edge the
  // state does, giving glitch-free registered outputs with no extra cycle
  // of latency. System reset lands in ST_ASSERT with a full counter, which
  // is what makes the power-on sequence happen without a separate path.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_ASSERT;
      cnt       <= ASSERT_LOAD;
      mask      <= '0;
      rst_out_n <= 1'b0;
      rst_out   <= 1'b1;
      ready     <= 1'b0;
      last_src  <= '0;
      seq_count <= '0;
    end else begin
      state     <= state_next;
      cnt       <= cnt_next;
      mask      <= mask_next;
      rst_out_n <= (state_next != ST_ASSERT);
      rst_out   <= (state_next == ST_ASSERT);
      ready     <= (state_next == ST_ACK) || (state_next == ST_IDLE);
      // Only sequences that served somebody are counted or reported; the
      // power-on ACK leaves last_src and seq_count untouched.
      if ((state == ST_ACK) && mask_any) begin
        last_src <= mask_low_idx;
        if (seq_count != SEQ_MAX) begin
          seq_count <= seq_count + SEQ_CNT_W'(1);
        end
      end
    end
  end

  // Output decode. ack is combinational from the state register so that a
  // system reset removes it immediately along with the served mask.
  always_comb begin
    busy = (state != ST_IDLE);
    ack  = (state == ST_ACK) ? mask : '0;
  end

endmodule

// File: tb/tb_axis_st_rst_ctrl.sv
// tb_axis_st_rst_ctrl
//
// Directed self-checking bench for axis_st_rst_ctrl with NUM_REQ=4, A=16,
// R=8 and a 4-bit sequence counter so saturation is reachable. Inputs are
// driven and outputs sampled on the falling clock edge; the DUT acts on
// the rising edge. "Edge j" below means the j-th rising edge after the
// stimulus was applied.
module tb_axis_st_rst_ctrl;

  localparam int NREQ  = 4;
  localparam int A     = 16;
  localparam int R     = 8;
  localparam int SEQ_W = 4;
  localparam int SEQ_LEN = A + R + 1;

  logic             clk = 1'b0;
  logic             reset_n = 1'b1;
  logic [NREQ-1:0]  req = '0;
  logic [NREQ-1:0]  ack;
  logic             rst_out_n;
  logic             rst_out;
  logic             ready;
  logic             busy;
  logic [1:0]       last_src;
  logic [SEQ_W-1:0] seq_count;

  int checks   = 0;
  int failures = 0;

  // 100 MHz-style free-running clock.
  always #5 clk = ~clk;

  axis_st_rst_ctrl #(
    .NUM_REQ        (NREQ),
    .ASSERT_CYCLES  (A),
    .RECOVERY_CYCLES(R),
    .SEQ_CNT_W      (SEQ_W)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .req      (req),
    .ack      (ack),
    .rst_out_n(rst_out_n),
    .rst_out  (rst_out),
    .ready    (ready),
    .busy     (busy),
    .last_src (last_src),
    .seq_count(seq_count)
  );

  // Assert system reset between clock edges and confirm the outputs take
  // their reset values without any clock, then hold it for two cycles.
  task automatic test_reset();
    @(negedge clk);
    req = '0;
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if (rst_out_n !== 1'b0 || rst_out !== 1'b1) begin
      failures++;
      $display("[TB] FAIL reset_rst_out got n=%b p=%b exp n=0 p=1", rst_out_n, rst_out);
    end
    checks++;
    if (ready !== 1'b0 || busy !== 1'b1) begin
      failures++;
      $display("[TB] FAIL reset_ready_busy got ready=%b busy=%b exp 0/1", ready, busy);
    end
    checks++;
    if (ack !== 4'b0000 || last_src !== 2'd0 || seq_count !== 4'd0) begin
      failures++;
      $display("[TB] FAIL reset_ack_src_cnt got ack=%b src=%0d cnt=%0d exp 0/0/0", ack, last_src, seq_count);
    end
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++;
      if (rst_out_n !== 1'b0 || ack !== 4'b0000) begin
        failures++;
        $display("[TB] FAIL reset_hold got rst_out_n=%b ack=%b exp 0/0", rst_out_n, ack);
      end
    end
  endtask

  // Release system reset on a falling edge and follow the power-on
  // sequence: low for edges 1..15, released at edge 16, ready at edge 24,
  // idle at edge 25, and never an ack.
  task automatic test_power_on(input logic [SEQ_W-1:0] exp_cnt);
    logic exp_n;
    logic exp_ready;
    logic exp_busy;
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 1; i <= SEQ_LEN; i++) begin
      @(negedge clk);
      exp_n     = (i >= A);
      exp_ready = (i >= A + R);
      exp_busy  = (i <= A + R);
      checks++;
      if (rst_out_n !== exp_n || rst_out !== !exp_n) begin
        failures++;
        $display("[TB] FAIL power_on_rst edge=%0d got n=%b p=%b exp n=%b", i, rst_out_n, rst_out, exp_n);
      end
      checks++;
      if (ready !== exp_ready || busy !== exp_busy) begin
        failures++;
        $display("[TB] FAIL power_on_ready edge=%0d got ready=%b busy=%b exp %b/%b", i, ready, busy, exp_ready, exp_busy);
      end
      checks++;
      if (ack !== 4'b0000) begin
        failures++;
        $display("[TB] FAIL power_on_ack edge=%0d got=%b exp=0000", i, ack);
      end
    end
    checks++;
    if (seq_count !== exp_cnt || last_src !== 2'd0) begin
      failures++;
      $display("[TB] FAIL power_on_cnt got cnt=%0d src=%0d exp cnt=%0d src=0", seq_count, last_src, exp_cnt);
    end
  endtask

  // One requester (index 2), full cycle-by-cycle timing of the sequence.
  task automatic test_single();
    logic            exp_n;
    logic            exp_ready;
    logic [NREQ-1:0] exp_ack;
    req = 4'b0100;
    for (int j = 1; j <= SEQ_LEN + 1; j++) begin
      @(negedge clk);
      exp_n     = (j > A);
      exp_ready = (j >= SEQ_LEN);
      exp_ack   = (j == SEQ_LEN) ? 4'b0100 : 4'b0000;
      checks++;
      if (rst_out_n !== exp_n || rst_out !== !exp_n) begin
        failures++;
        $display("[TB] FAIL single_rst edge=%0d got n=%b p=%b exp n=%b", j, rst_out_n, rst_out, exp_n);
      end
      checks++;
      if (ready !== exp_ready) begin
        failures++;
        $display("[TB] FAIL single_ready edge=%0d got=%b exp=%b", j, ready, exp_ready);
      end
      checks++;
      if (ack !== exp_ack) begin
        failures++;
        $display("[TB] FAIL single_ack edge=%0d got=%b exp=%b", j, ack, exp_ack);
      end
      if (j == SEQ_LEN) req = 4'b0000;
    end
    checks++;
    if (last_src !== 2'd2 || seq_count !== 4'd1 || busy !== 1'b0) begin
      failures++;
      $display("[TB] FAIL single_result got src=%0d cnt=%0d busy=%b exp 2/1/0", last_src, seq_count, busy);
    end
  endtask

  // Two requesters raised together in IDLE share one sequence.
  task automatic test_simultaneous();
    req = 4'b1010;
    for (int j = 1; j < SEQ_LEN; j++) begin
      @(negedge clk);
      checks++;
      if (ack !== 4'b0000 || busy !== 1'b1) begin
        failures++;
        $display("[TB] FAIL simul_early edge=%0d got ack=%b busy=%b exp 0000/1", j, ack, busy);
      end
    end
    @(negedge clk);
    checks++;
    if (ack !== 4'b1010 || ready !== 1'b1) begin
      failures++;
      $display("[TB] FAIL simul_ack got ack=%b ready=%b exp 1010/1", ack, ready);
    end
    req = 4'b0000;
    @(negedge clk);
    checks++;
    if (last_src !== 2'd1 || seq_count !== 4'd2 || busy !== 1'b0) begin
      failures++;
      $display("[TB] FAIL simul_result got src=%0d cnt=%0d busy=%b exp 1/2/0", last_src, seq_count, busy);
    end
  endtask

  // req[0] joins during ASSERT cycle 5; req[3] arrives in RECOVER and must
  // wait for a second sequence whose ack lands 26 cycles after the first.
  task automatic test_merge_defer();
    req = 4'b0100;
    for (int j = 1; j <= 2 * SEQ_LEN + 2; j++) begin
      @(negedge clk);
      if (j == 5)  req[0] = 1'b1;
      if (j == 18) req[3] = 1'b1;
      if (j == SEQ_LEN) begin
        checks++;
        if (ack !== 4'b0101) begin
          failures++;
          $display("[TB] FAIL merge_ack got=%b exp=0101", ack);
        end
        req = 4'b1000;
      end else if (j == SEQ_LEN + 1) begin
        checks++;
        if (busy !== 1'b0 || ack !== 4'b0000 || last_src !== 2'd0 || seq_count !== 4'd3) begin
          failures++;
          $display("[TB] FAIL merge_idle got busy=%b ack=%b src=%0d cnt=%0d exp 0/0000/0/3", busy, ack, last_src, seq_count);
        end
      end else if (j == SEQ_LEN + 2) begin
        checks++;
        if (rst_out_n !== 1'b0 || ready !== 1'b0) begin
          failures++;
          $display("[TB] FAIL defer_start got rst_out_n=%b ready=%b exp 0/0", rst_out_n, ready);
        end
      end else if (j == 2 * SEQ_LEN + 1) begin
        checks++;
        if (ack !== 4'b1000) begin
          failures++;
          $display("[TB] FAIL defer_ack got=%b exp=1000", ack);
        end
        req = 4'b0000;
      end else if (j == 2 * SEQ_LEN + 2) begin
        checks++;
        if (last_src !== 2'd3 || seq_count !== 4'd4 || busy !== 1'b0) begin
          failures++;
          $display("[TB] FAIL defer_result got src=%0d cnt=%0d busy=%b exp 3/4/0", last_src, seq_count, busy);
        end
      end else begin
        checks++;
        if (ack !== 4'b0000) begin
          failures++;
          $display("[TB] FAIL merge_noack edge=%0d got=%b exp=0000", j, ack);
        end
      end
    end
  endtask

  // System reset lands in RECOVER cycle 3: outputs drop at once, the
  // served requester is never acked, and power-on reruns on release.
  task automatic test_mid_reset();
    req = 4'b0010;
    for (int j = 1; j <= A + 3; j++) begin
      @(negedge clk);
    end
    checks++;
    if (rst_out_n !== 1'b1 || ready !== 1'b0 || busy !== 1'b1) begin
      failures++;
      $display("[TB] FAIL midrst_pre got n=%b ready=%b busy=%b exp 1/0/1", rst_out_n, ready, busy);
    end
    #2 reset_n = 1'b0;
    req = 4'b0000;
    #1;
    checks++;
    if (rst_out_n !== 1'b0 || rst_out !== 1'b1 || ready !== 1'b0 || busy !== 1'b1) begin
      failures++;
      $display("[TB] FAIL midrst_async got n=%b p=%b ready=%b busy=%b exp 0/1/0/1", rst_out_n, rst_out, ready, busy);
    end
    checks++;
    if (ack !== 4'b0000 || seq_count !== 4'd0 || last_src !== 2'd0) begin
      failures++;
      $display("[TB] FAIL midrst_vals got ack=%b cnt=%0d src=%0d exp 0000/0/0", ack, seq_count, last_src);
    end
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++;
      if (ack !== 4'b0000 || rst_out_n !== 1'b0) begin
        failures++;
        $display("[TB] FAIL midrst_hold got ack=%b n=%b exp 0000/0", ack, rst_out_n);
      end
    end
    test_power_on(4'd0);
  endtask

  // Seventeen requested sequences into a 4-bit counter: counts 1..15, then
  // holds at 4'hF.
  task automatic test_saturation();
    logic [SEQ_W-1:0] exp_cnt;
    for (int k = 1; k <= 17; k++) begin
      req = 4'b0001;
      for (int j = 1; j <= SEQ_LEN; j++) begin
        @(negedge clk);
      end
      checks++;
      if (ack !== 4'b0001) begin
        failures++;
        $display("[TB] FAIL sat_ack seq=%0d got=%b exp=0001", k, ack);
      end
      req = 4'b0000;
      @(negedge clk);
      exp_cnt = (k > 15) ? 4'hF : SEQ_W'(k);
      checks++;
      if (seq_count !== exp_cnt) begin
        failures++;
        $display("[TB] FAIL sat_count seq=%0d got=%0d exp=%0d", k, seq_count, exp_cnt);
      end
    end
  endtask

  initial begin
    test_reset();
    test_power_on(4'd0);
    test_single();
    test_simultaneous();
    test_merge_defer();
    test_mid_reset();
    test_saturation();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
